// File: rtl/regfile.sv
// Register file with two registered read ports, one write port, and write-to-read bypass.
// Register 0 always reads zero; register 10 (a0) is also brought out as a registered output.
module regfile #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] AD1,
   input  logic [ADDRESS_WIDTH-1:0] AD2,
   input  logic [ADDRESS_WIDTH-1:0] AD3,
   input  logic                     WE3,
   input  logic [DATA_WIDTH-1:0]    WD3,
   output logic [DATA_WIDTH-1:0]    RD1,
   output logic [DATA_WIDTH-1:0]    RD2,
   output logic [DATA_WIDTH-1:0]    a0
);

   localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DATA_WIDTH-1:0] v1, v2, va0;

   // Read values as they will stand after this edge: x0 forced to zero, then bypass.
   always_comb begin
      v1 = regs[AD1];
      if (WE3 && (AD3 == AD1)) v1 = WD3;
      if (AD1 == '0)           v1 = '0;

      v2 = regs[AD2];
      if (WE3 && (AD3 == AD2)) v2 = WD3;
      if (AD2 == '0)           v2 = '0;

      va0 = regs[A0_IDX];
      if (WE3 && (AD3 == A0_IDX)) va0 = WD3;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '{default: '0};
      end else if (WE3 && (AD3 != '0)) begin
         regs[AD3] <= WD3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         RD1 <= '0;
         RD2 <= '0;
         a0  <= '0;
      end else begin
         RD1 <= v1;
         RD2 <= v2;
         a0  <= va0;
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: the stimulus process queues hand-computed expected outputs
// for each edge; the monitor pops one entry after each edge and compares RD1, RD2 and a0.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  AD1 = '0, AD2 = '0, AD3 = '0;
   logic        WE3 = 1'b0;
   logic [11:0] WD3 = '0;
   logic [11:0] RD1, RD2, a0;

   typedef struct {
      string       name;
      logic [11:0] rd1;
      logic [11:0] rd2;
      logic [11:0] a0;
   } exp_t;

   exp_t q[$];
   int compared   = 0;
   int mismatched = 0;

   regfile #(.ADDRESS_WIDTH(5), .DATA_WIDTH(12)) dut (
      .clk(clk), .rst(rst),
      .AD1(AD1), .AD2(AD2), .AD3(AD3),
      .WE3(WE3), .WD3(WD3),
      .RD1(RD1), .RD2(RD2), .a0(a0)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got 0x%03h, required 0x%03h", name, act, req);
      end
   endtask

   // Monitor: every edge is an output event once something is queued.
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check({e.name, ".RD1"}, RD1, e.rd1);
         check({e.name, ".RD2"}, RD2, e.rd2);
         check({e.name, ".a0"},  a0,  e.a0);
      end
   end

   task automatic step(input string name, input logic r, input logic we,
                       input logic [4:0] ad3, input logic [11:0] wd3,
                       input logic [4:0] ad1, input logic [4:0] ad2,
                       input logic [11:0] e1, input logic [11:0] e2, input logic [11:0] ea0);
      exp_t e;
      @(negedge clk);
      rst = r; WE3 = we; AD3 = ad3; WD3 = wd3; AD1 = ad1; AD2 = ad2;
      e.name = name; e.rd1 = e1; e.rd2 = e2; e.a0 = ea0;
      q.push_back(e);
   endtask

   initial begin
      //    name          rst we  ad3  wd3      ad1 ad2  RD1      RD2      a0
      step("reset",       1, 1,  5, 12'hABC,  5, 10, 12'h000, 12'h000, 12'h000);
      step("post_reset",  0, 0,  5, 12'hABC,  5, 10, 12'h000, 12'h000, 12'h000);
      step("wr3_byp",     0, 1,  3, 12'h123,  3,  0, 12'h123, 12'h000, 12'h000);
      step("wr10",        0, 1, 10, 12'h7FF,  3, 10, 12'h123, 12'h7FF, 12'h7FF);
      step("rd3_10",      0, 0, 10, 12'h000,  3, 10, 12'h123, 12'h7FF, 12'h7FF);
      step("wr_x0",       0, 1,  0, 12'hFFF,  0,  0, 12'h000, 12'h000, 12'h7FF);
      step("rd_x0",       0, 0,  0, 12'hFFF,  0,  0, 12'h000, 12'h000, 12'h7FF);
      step("pre7",        0, 1,  7, 12'h111,  0,  3, 12'h000, 12'h123, 12'h7FF);
      step("byp7_both",   0, 1,  7, 12'h222,  7,  7, 12'h222, 12'h222, 12'h7FF);
      step("hold7",       0, 0,  7, 12'h333,  7,  7, 12'h222, 12'h222, 12'h7FF);
      step("wr1",         0, 1,  1, 12'h800,  1,  2, 12'h800, 12'h000, 12'h7FF);
      step("wr2",         0, 1,  2, 12'h800,  1,  2, 12'h800, 12'h800, 12'h7FF);
      step("alu_wrap",    0, 1, 10, 12'h000, 10,  1, 12'h000, 12'h800, 12'h000);
      step("alu_fff",     0, 1, 10, 12'hFFF, 10,  2, 12'hFFF, 12'h800, 12'hFFF);
      step("b2b_a",       0, 1, 10, 12'hABC, 10, 10, 12'hABC, 12'hABC, 12'hABC);
      step("b2b_b",       0, 1, 10, 12'h5A5, 10,  3, 12'h5A5, 12'h123, 12'h5A5);
      step("wr4",         0, 1,  4, 12'h055,  4,  7, 12'h055, 12'h222, 12'h5A5);
      step("rd4",         0, 0,  4, 12'h000,  4,  4, 12'h055, 12'h055, 12'h5A5);
      step("mid_reset",   1, 1,  4, 12'h0AA,  4, 10, 12'h000, 12'h000, 12'h000);
      step("rd4_cleared", 0, 0,  4, 12'h0AA,  4, 10, 12'h000, 12'h000, 12'h000);
      step("rd7_3_clr",   0, 0,  0, 12'h000,  7,  3, 12'h000, 12'h000, 12'h000);
      step("byp_after",   0, 1,  3, 12'h321,  3,  1, 12'h321, 12'h000, 12'h000);
      step("x0_bypass",   0, 1,  0, 12'hFFF,  0,  3, 12'h000, 12'h321, 12'h000);
      @(negedge clk);
      WE3 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      compared++;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending, required 0 pending", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, required finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
